// File: rtl/core_pkg.sv
// Shared core constants and types for the register file and the stages that use it.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package core_pkg;

    localparam int REG_DATA_W    = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int REG_COUNT     = 2 ** REG_ADDR_W;
    localparam int ZERO_REG_ADDR = 0;

    // Operand/address types shared with decode and ALU stages.
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile.sv
// General-purpose register file: one combinational read port, one clocked write port.
// Latency: read 0 cycles from read_addr; a write at edge N is visible right after edge N.
// Backpressure: none; writes always accepted, no stall or handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset, clears every entry
//   read_addr    read address; read_data is the entry at that address
//   write_addr   write address
//   write_data   data committed on a clock edge when write_enable is high
//   write_enable active-high write strobe
module regfile
    import core_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic              write_enable
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_ADDR);

    logic [DATA_W-1:0] mem [DEPTH];

    logic write_is_zero;
    logic read_is_zero;

    assign write_is_zero = (ZERO_REG != 0) && (write_addr == ZERO_ADDR);
    assign read_is_zero  = (ZERO_REG != 0) && (read_addr == ZERO_ADDR);

    // Reset wins over a coincident write; the write is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_enable && !write_is_zero) begin
            mem[write_addr] <= write_data;
        end
    end

    // No write bypass: a same-address read shows the old value until the edge.
    // Entry 0 is masked here so it reads zero even before the first reset.
    assign read_data = read_is_zero ? '0 : mem[read_addr];

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] read_data;
    logic [31:0] write_data;
    logic [4:0]  read_addr;
    logic [4:0]  write_addr;
    logic        write_enable;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [32];
    logic [31:0] sb_q [$];

    regfile dut (
        .clk          (clk),
        .rst          (rst),
        .read_data    (read_data),
        .write_data   (write_data),
        .read_addr    (read_addr),
        .write_addr   (write_addr),
        .write_enable (write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock edge; the model applies the same edge using the inputs held across it.
    task automatic step();
        logic        r;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        r  = rst;
        we = write_enable;
        wa = write_addr;
        wd = write_data;
        @(posedge clk);
        #1;
        if (!r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    // Scoreboard read: expectation queued when the address is driven, checked when data settles.
    task automatic rd(input string tag, input logic [4:0] a);
        logic [31:0] e;
        read_addr = a;
        sb_q.push_back(expect_rd(a));
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, read_data, 32'hxxxx_xxxx);
        end else begin
            e = sb_q.pop_front();
            chk(tag, read_data, e);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        write_addr   = a;
        write_data   = d;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd($sformatf("%s_a%0d", tag, i), 5'(i));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'hxxxx_xxxx;
        rst          = 1'b1;
        write_enable = 1'b0;
        write_addr   = 5'd0;
        write_data   = 32'h0;
        read_addr    = 5'd0;

        // Entry 0 reads zero even before any reset edge.
        rd("zero_pre_reset", 5'd0);

        // 1. Reset clear, with a write held during reset that must be discarded.
        @(negedge clk);
        rst          = 1'b0;
        write_enable = 1'b1;
        write_addr   = 5'd3;
        write_data   = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        rst          = 1'b1;
        write_enable = 1'b0;
        sweep("reset_clear");

        // 5. Write-enable gating.
        @(negedge clk);
        write_addr   = 5'd7;
        write_data   = 32'h1234_5678;
        write_enable = 1'b0;
        step();
        rd("we_gate", 5'd7);

        // 2. Write/read-back over all non-zero addresses.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000_0000 + i);
        sweep("readback");

        // 3. Zero register ignores writes.
        wr(5'd0, 32'hFFFF_FFFF);
        rd("zero_write", 5'd0);
        rd("zero_neighbor", 5'd1);

        // 4. Read-during-write on the same address.
        wr(5'd5, 32'hAAAA_AAAA);
        @(negedge clk);
        write_addr   = 5'd5;
        write_data   = 32'h5555_5555;
        write_enable = 1'b1;
        rd("rdw_before", 5'd5);
        chk("rdw_before_abs", read_data, 32'hAAAA_AAAA);
        step();
        write_enable = 1'b0;
        rd("rdw_after", 5'd5);
        chk("rdw_after_abs", read_data, 32'h5555_5555);

        // 6. Reset mid-operation, one edge, with a concurrent write that must be dropped.
        rd("pre_reset_a31", 5'd31);
        @(negedge clk);
        rst          = 1'b0;
        write_enable = 1'b1;
        write_addr   = 5'd9;
        write_data   = 32'hCAFE_F00D;
        step();
        @(negedge clk);
        rst          = 1'b1;
        write_enable = 1'b0;
        sweep("mid_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Single-read-port, single-write-port general-purpose register file for the core1 datapath: 32 registers of 32 bits.
- Reads are combinational from `read_addr`.
- Writes commit on the rising clock edge when `write_enable` is high.
- Register 0 is hardwired to zero, following the usual RISC convention.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32 entries.
- ZERO_REG, 1, when 1, entry 0 always reads 0 and ignores writes; when 0, entry 0 is an ordinary register.

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  reset, synchronous, active-low: asserted when 0 and sampled on the rising edge of clk.
- read_data  output  DATA_W  contents of the entry at read_addr.
- write_data  input  DATA_W  data written on a qualifying clock edge.
- read_addr  input  ADDR_W  read address.
- write_addr  input  ADDR_W  write address.
- write_enable  input  1  active-high write strobe.

Behaviour:
- Storage: array of 2**ADDR_W entries, each DATA_W bits.
- Reset:
  - On a rising edge with rst==0, every entry is cleared to 0.
  - Reset has priority over a simultaneous write; that write is discarded.
  - read_data therefore reads 0 for every address from the edge after reset onward.
  - No asynchronous reset path exists. Before the first reset edge, contents are undefined (X in simulation).
- Write:
  - On a rising edge with rst==1 and write_enable==1, entry[write_addr] <= write_data.
  - All other entries hold.
  - If write_enable==0, nothing changes.
- Zero register: with ZERO_REG==1, writes to address 0 are ignored and read_addr==0 always yields 0, including before any reset.
- Read:
  - Purely combinational: read_data = entry[read_addr].
  - Zero cycles of latency from a read_addr change.
- Read-during-write, same address, same cycle:
  - read_data shows the old value until the clock edge, then the new value. No internal bypass is provided.
  - A write at edge N is visible on read_data immediately after edge N.
- Address range: every ADDR_W-bit value is valid, so there is no out-of-range case and no wrap-around.
- No handshake, no stall, no error outputs.

Decomposition:
- Shared package `core_pkg` holds the register-file constants: REG_DATA_W=32, REG_ADDR_W=5, REG_COUNT=32, ZERO_REG_ADDR=0.
- The package also holds the typedefs `reg_addr_t` (logic [4:0]) and `reg_data_t` (logic [31:0]); the core's decode and ALU stages reuse these.
- No sub-module: the block is one array, one write process and one read mux.

Test Plan:
1. Reset clear:
   - Stimulus: hold rst=0 for 5 edges with write_enable=1, write_addr=3, write_data=32'hDEADBEEF; release rst=1; sweep read_addr 0..31.
   - Required: read_data==0 for every address (the write during reset is discarded).
2. Write/read-back:
   - Stimulus: write 32'h1000_0000+i to each address i=1..31, one per edge.
   - Required: reading each address returns its value; address 0 reads 0.
3. Zero register:
   - Stimulus: write 32'hFFFF_FFFF to address 0.
   - Required: read_addr=0 gives 32'h0000_0000.
4. Read-during-write:
   - Stimulus: entry 5 holds 32'hAAAA_AAAA; drive read_addr=5, write_addr=5, write_data=32'h5555_5555, write_enable=1.
   - Required: read_data==32'hAAAA_AAAA before the edge and 32'h5555_5555 after it.
5. Write-enable gating:
   - Stimulus: write_enable=0, write_addr=7, write_data=32'h1234_5678.
   - Required: entry 7 keeps its prior value (0 after reset).
6. Reset mid-operation:
   - Stimulus: after scenario 2, pulse rst=0 for one edge.
   - Required: all entries read 0 on the following cycle.
